// File: rtl/piezo_alert_sequencer_pkg.sv
// piezo_alert_sequencer_pkg: shared FSM encoding and clock-derived tick constants for the alert engine.
package piezo_alert_sequencer_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;
    localparam int unsigned CLK_FREQ_HZ   = 50_000_000;
    localparam int unsigned TICKS_HALF_S  = CLK_FREQ_HZ / 2;
    localparam int unsigned TICKS_2S      = CLK_FREQ_HZ * 2;
    localparam int unsigned TICKS_5S      = CLK_FREQ_HZ * 5;
endpackage

// File: rtl/piezo_alert_sequencer_channel.sv
// piezo_alert_channel: one periodic alert source; a period counter that raises a sticky pending flag.
module piezo_alert_channel #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] period,
    input  logic             clr,
    output logic             pending
);
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] limit;
    assign limit = (period == '0) ? '0 : period - CNT_W'(1);
    // a set on the same edge as a grant-clear wins, so no beep is lost
    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            cnt     <= '0;
            pending <= 1'b0;
        end else if (cnt >= limit) begin
            cnt     <= '0;
            pending <= 1'b1;
        end else begin
            cnt     <= cnt + CNT_W'(1);
            pending <= pending & ~clr;
        end
    end
endmodule

// File: rtl/piezo_alert_sequencer.sv
// piezo_alert_sequencer: NUM_CH periodic alert channels, fixed-priority arbiter and shared beep playback FSM.
module piezo_alert_sequencer
    import piezo_alert_sequencer_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 32,
    parameter int TONE_W    = 16,
    parameter int GAP_TICKS = 1000,
    parameter int IDX_W     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic [NUM_CH*CNT_W-1:0]  ch_period,
    input  logic [NUM_CH*CNT_W-1:0]  ch_on,
    input  logic [NUM_CH*TONE_W-1:0] ch_tone_half,
    input  logic                     mute,
    output logic                     piezo_out,
    output logic                     busy,
    output logic [IDX_W-1:0]         active_ch,
    output logic [NUM_CH-1:0]        pending
);
    state_t              state, state_n;
    logic [IDX_W-1:0]    grant, active_n;
    logic [NUM_CH-1:0]   clr;
    logic [CNT_W-1:0]    on_len, on_len_n, phase_cnt, phase_cnt_n, on_g;
    logic [TONE_W-1:0]   tone_half, tone_half_n, tone_cnt, tone_cnt_n;
    logic                tone_level, tone_level_n;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        piezo_alert_channel #(.CNT_W(CNT_W)) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .enable  (ch_enable[i]),
            .period  (ch_period[i*CNT_W +: CNT_W]),
            .clr     (clr[i]),
            .pending (pending[i])
        );
    end
    always_comb begin
        grant = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (pending[i]) grant = IDX_W'(i);
    end
    assign on_g = ch_on[int'(grant)*CNT_W +: CNT_W];
    assign busy = (state != ST_IDLE);
    always_comb begin
        state_n      = state;
        active_n     = active_ch;
        on_len_n     = on_len;
        tone_half_n  = tone_half;
        phase_cnt_n  = phase_cnt;
        tone_cnt_n   = tone_cnt;
        tone_level_n = tone_level;
        clr          = '0;
        unique case (state)
            ST_IDLE: if (|pending) begin
                state_n      = ST_ON;
                active_n     = grant;
                clr[grant]   = 1'b1;
                on_len_n     = (on_g == '0) ? CNT_W'(1) : on_g;
                tone_half_n  = ch_tone_half[int'(grant)*TONE_W +: TONE_W];
                phase_cnt_n  = '0;
                tone_cnt_n   = '0;
                tone_level_n = 1'b1;
            end
            // disabling the playing channel cuts the beep short
            ST_ON: if (!ch_enable[active_ch] || phase_cnt == on_len - CNT_W'(1)) begin
                state_n      = ST_GAP;
                phase_cnt_n  = '0;
                tone_level_n = 1'b0;
            end else begin
                phase_cnt_n = phase_cnt + CNT_W'(1);
                if (tone_half != '0) begin
                    tone_cnt_n   = (tone_cnt == tone_half - TONE_W'(1)) ? '0 : tone_cnt + TONE_W'(1);
                    tone_level_n = (tone_cnt == tone_half - TONE_W'(1)) ? ~tone_level : tone_level;
                end
            end
            ST_GAP: if (phase_cnt == CNT_W'(GAP_TICKS - 1)) state_n = ST_IDLE;
                    else phase_cnt_n = phase_cnt + CNT_W'(1);
            default: state_n = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            active_ch  <= '0;
            on_len     <= '0;
            tone_half  <= '0;
            phase_cnt  <= '0;
            tone_cnt   <= '0;
            tone_level <= 1'b0;
            piezo_out  <= 1'b0;
        end else begin
            state      <= state_n;
            active_ch  <= active_n;
            on_len     <= on_len_n;
            tone_half  <= tone_half_n;
            phase_cnt  <= phase_cnt_n;
            tone_cnt   <= tone_cnt_n;
            tone_level <= tone_level_n;
            piezo_out  <= tone_level_n & ~mute;
        end
    end
endmodule

// File: tb/tb_piezo_alert_sequencer.sv
// tb_piezo_alert_sequencer: scenario tasks with a per-cycle expected-output scoreboard queue.
module tb_piezo_alert_sequencer;
    localparam int NUM_CH = 4, CNT_W = 32, TONE_W = 16, GAP = 2, IDX_W = 2;
    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_CH-1:0]        ch_enable = '0;
    logic [NUM_CH*CNT_W-1:0]  ch_period = '0;
    logic [NUM_CH*CNT_W-1:0]  ch_on = '0;
    logic [NUM_CH*TONE_W-1:0] ch_tone_half = '0;
    logic                     mute = 1'b0;
    logic                     piezo_out, busy;
    logic [IDX_W-1:0]         active_ch;
    logic [NUM_CH-1:0]        pending;
    typedef struct packed {
        logic       piezo;
        logic       busy;
        logic [1:0] act;
        logic [3:0] pend;
    } obs_t;
    obs_t exp_q[$];
    int errors = 0;
    int checks = 0;
    piezo_alert_sequencer #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .TONE_W(TONE_W), .GAP_TICKS(GAP), .IDX_W(IDX_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ch_enable    (ch_enable),
        .ch_period    (ch_period),
        .ch_on        (ch_on),
        .ch_tone_half (ch_tone_half),
        .mute         (mute),
        .piezo_out    (piezo_out),
        .busy         (busy),
        .active_ch    (active_ch),
        .pending      (pending)
    );
    always #5 clk = ~clk;
    task automatic push(input logic p, input logic b, input logic [1:0] a, input logic [3:0] pd);
        obs_t e;
        e = '{piezo: p, busy: b, act: a, pend: pd};
        exp_q.push_back(e);
    endtask
    task automatic step(input string name, input int k);
        obs_t e, o;
        @(posedge clk);
        #1;
        o = '{piezo: piezo_out, busy: busy, act: active_ch, pend: pending};
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL %s k=%0d: got piezo=%b busy=%b act=%0d pend=%b, want piezo=%b busy=%b act=%0d pend=%b",
                     name, k, o.piezo, o.busy, o.act, o.pend, e.piezo, e.busy, e.act, e.pend);
        end
    endtask
    task automatic cfg(input int ch, input logic en, input logic [31:0] per, input logic [31:0] on,
                       input logic [15:0] th);
        ch_enable[ch] = en;
        ch_period[ch*CNT_W +: CNT_W] = per;
        ch_on[ch*CNT_W +: CNT_W] = on;
        ch_tone_half[ch*TONE_W +: TONE_W] = th;
    endtask
    task automatic do_reset();
        ch_enable = '0;
        ch_period = '0;
        ch_on = '0;
        ch_tone_half = '0;
        mute = 1'b0;
        rst_n = 1'b0;
        push(0, 0, 0, 4'b0000);
        step("reset_pre", 0);
        rst_n = 1'b1;
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        ch_enable = '1;
        ch_period = '0;
        ch_on = '0;
        for (int k = 1; k <= 3; k++) begin
            push(0, 0, 0, 4'b0000);
            step("reset_hold", k);
        end
    endtask
    task automatic test_dc();
        do_reset();
        cfg(0, 1, 10, 4, 0);
        for (int k = 1; k <= 30; k++) begin
            push((k >= 11 && k <= 14) || (k >= 21 && k <= 24),
                 (k >= 11 && k <= 16) || (k >= 21 && k <= 26),
                 0, (k % 10 == 0) ? 4'b0001 : 4'b0000);
            step("dc", k);
        end
    endtask
    task automatic test_tone();
        do_reset();
        cfg(0, 1, 20, 12, 3);
        for (int k = 1; k <= 40; k++) begin
            push((k >= 21 && k <= 32) && (((k - 21) / 3) % 2 == 0),
                 k >= 21 && k <= 34, 0, (k == 20 || k == 40) ? 4'b0001 : 4'b0000);
            step("tone", k);
        end
    endtask
    task automatic test_priority();
        logic [3:0] pd;
        do_reset();
        cfg(0, 1, 10, 4, 0);
        cfg(2, 1, 10, 3, 0);
        for (int k = 1; k <= 22; k++) begin
            pd = (k == 10 || k >= 20) ? 4'b0101 : (k >= 11 && k <= 17) ? 4'b0100 : 4'b0000;
            push((k >= 11 && k <= 14) || (k >= 18 && k <= 20),
                 (k >= 11 && k <= 16) || (k >= 18 && k <= 22),
                 (k >= 18) ? 2'd2 : 2'd0, pd);
            step("priority", k);
        end
    endtask
    task automatic test_abort();
        do_reset();
        cfg(1, 1, 10, 6, 0);
        for (int k = 1; k <= 36; k++) begin
            if (k == 13) ch_enable[1] = 1'b0;
            if (k == 21) ch_enable[1] = 1'b1;
            push(k == 11 || k == 12 || (k >= 31 && k <= 36),
                 (k >= 11 && k <= 14) || k >= 31,
                 (k >= 11) ? 2'd1 : 2'd0, (k == 10 || k == 30) ? 4'b0010 : 4'b0000);
            step("abort", k);
        end
    endtask
    task automatic test_mute();
        do_reset();
        mute = 1'b1;
        cfg(0, 1, 5, 20, 0);
        for (int k = 1; k <= 35; k++) begin
            push(0, (k >= 6 && k <= 27) || k >= 29, 0,
                 (k == 5 || (k >= 10 && k <= 28) || k >= 30) ? 4'b0001 : 4'b0000);
            step("mute", k);
        end
        mute = 1'b0;
    endtask
    task automatic test_reset_mid();
        do_reset();
        cfg(0, 1, 10, 6, 0);
        for (int k = 1; k <= 26; k++) begin
            if (k == 13) rst_n = 1'b0;
            if (k == 14) rst_n = 1'b1;
            if (k < 13) push(k >= 11, k >= 11, 0, (k == 10) ? 4'b0001 : 4'b0000);
            else if (k == 13) push(0, 0, 0, 4'b0000);
            else push(k >= 24, k >= 24, 0, (k == 23) ? 4'b0001 : 4'b0000);
            step("reset_mid", k);
        end
    endtask
    initial begin
        test_reset();
        test_dc();
        test_tone();
        test_priority();
        test_abort();
        test_mute();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
